fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that produces the instruction/PC pair consumed by decode_stage. It owns the PC register and issues word fetches to instruction memory over a request/ready + response-valid handshake, with at most one request outstanding. It holds results in an IF/ID output register backed by a one-entry skid buffer. It accepts stall and redirect (ID_PCSrc/branch target) from the decode side and discards in-flight fetches made stale by a redirect.

Parameters:
DATA_WIDTH, 32, instruction/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction presented when output is invalid (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
IF_imem_req_o  out  1  fetch request valid
IF_imem_addr_o  out  DATA_WIDTH  fetch address, always word-aligned
IF_imem_ready_i  in  1  memory accepts request this cycle
IF_imem_rvalid_i  in  1  response valid, ≥1 cycle after acceptance, in order
IF_imem_rdata_i  in  DATA_WIDTH  fetched instruction
ID_stall_i  in  1  decode holds its input; output register must not change
ID_PCSrc_i  in  1  redirect request from decode
ID_branch_target_addr_i  in  DATA_WIDTH  redirect target
IF_instruction_o  out  DATA_WIDTH  instruction to decode
IF_pc_o  out  DATA_WIDTH  PC of IF_instruction_o
IF_valid_o  out  1  output pair is a real fetched instruction

Behaviour:
- Reset (async assert, sync deassert into clk domain):
  - pc_q=RESET_PC; state=S_REQ; skid empty.
  - IF_valid_o=0, IF_instruction_o=NOP_INSTR, IF_pc_o=0.
  - IF_imem_req_o=0 while rst_n=0. IF_imem_addr_o=pc_q.
- Memory shares rst_n. No response survives reset.
- States:
  - S_REQ: IF_imem_req_o=!skid_valid. On req&&ready: pending_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32), go S_WAIT.
  - S_WAIT: req=0. On rvalid: deliver {rdata,pending_pc}, go S_REQ.
  - S_DISCARD: req=0. On rvalid: drop data, go S_REQ.
- Steady-state throughput: one instruction per 2 cycles with a single-cycle memory (accept N, rvalid N+1, next accept N+1 earliest in S_REQ at N+2).
- Delivery:
  - If !IF_valid_o or !ID_stall_i, data goes to the output register and valid=1.
  - Otherwise it goes to the skid buffer.
- Consumption: when ID_stall_i=0, the output register loads in this priority order: skid entry, else new delivery, else bubble (valid=0, NOP_INSTR, pc 0). When ID_stall_i=1, the output register holds.
- Skid and rvalid never coincide: a skid fill implies nothing is outstanding, and requests are gated while the skid is full.
- Redirect is honoured only when ID_PCSrc_i=1 && ID_stall_i=0. When honoured:
  - pc_q <= {target[31:2],2'b00}.
  - Output register becomes a bubble; skid cleared.
  - S_WAIT without rvalid -> S_DISCARD.
  - S_WAIT with rvalid same cycle -> data dropped, S_REQ.
  - S_REQ with a request accepted same cycle -> that fetch is stale; go S_DISCARD, pc_q=target (the +4 increment is not applied).
  - S_DISCARD stays S_DISCARD.
- Redirect has priority over the PC increment and over delivery.
- rvalid in S_REQ is ignored (protocol violation; no state change).
- Redirect while ID_stall_i=1 is ignored entirely.

Test Plan:
1. Release reset; memory ready=1, rvalid one cycle after accept, rdata=addr^32'hA5A5_0000. Required: first req the cycle after reset release at addr 0. Outputs (pc,instr) = (0,A5A50000), (4,A5A50004), (8,A5A50008), in order, each valid, 2-cycle spacing.
2. Assert ID_stall_i for 5 cycles starting when pc 4 is on the output. Required: output holds pc 4. pc 8 goes to skid. req stays 0 while the skid is full. After release: pc 8 then pc 12, no drop, no duplicate.
3. Hold ready=1 and delay rvalid 3 cycles. Pulse ID_PCSrc_i with target 0x7C while in S_WAIT. Required: output becomes a bubble, the stale response is dropped, the next req addr is 0x7C, and the next valid output is pc 0x7C.
4. Redirect to 0x200 in the same cycle as rvalid for pc 0x10. Required: data 0x10 never appears valid; the next fetch addr is 0x200.
5. Target 0x7E -> fetch addr 0x7C. RESET_PC=32'hFFFF_FFFC -> second fetch addr 0x0000_0000 (wrap).
6. Assert rst_n=0 mid-S_WAIT with the output valid. Required: all outputs return to reset values immediately (asynchronous). After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches to instruction
// memory (one request outstanding at most), and presents {instruction, pc}
// to decode through an IF/ID register backed by a one-entry skid buffer.
//
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   IF_imem_req_o/addr_o       fetch request and word-aligned address
//   IF_imem_ready_i            memory accepts the request this cycle
//   IF_imem_rvalid_i/rdata_i   in-order fetch response
//   ID_stall_i                 decode holds its input
//   ID_PCSrc_i                 redirect request from decode
//   ID_branch_target_addr_i    redirect target
//   IF_instruction_o/pc_o      instruction and its PC for decode
//   IF_valid_o                 output pair is a real fetched instruction
module fetch_stage #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  IF_imem_req_o,
  output logic [DATA_WIDTH-1:0] IF_imem_addr_o,
  input  logic                  IF_imem_ready_i,
  input  logic                  IF_imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] IF_imem_rdata_i,
  input  logic                  ID_stall_i,
  input  logic                  ID_PCSrc_i,
  input  logic [DATA_WIDTH-1:0] ID_branch_target_addr_i,
  output logic [DATA_WIDTH-1:0] IF_instruction_o,
  output logic [DATA_WIDTH-1:0] IF_pc_o,
  output logic                  IF_valid_o
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  rst_done_q;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic                  req_c;
  logic                  accept_c;
  logic                  redirect_c;
  logic                  deliver_c;
  logic [DATA_WIDTH-1:0] target_c;

  // Requests stay off until the first edge after reset release and while the skid is full.
  assign req_c      = rst_done_q && (state_q == S_REQ) && !skid_valid_q;
  assign accept_c   = req_c && IF_imem_ready_i;
  assign redirect_c = ID_PCSrc_i && !ID_stall_i;
  assign deliver_c  = (state_q == S_WAIT) && IF_imem_rvalid_i && !redirect_c;
  assign target_c   = ID_branch_target_addr_i & ~DATA_WIDTH'(3);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect turns any accepted or outstanding fetch stale.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (accept_c) state_d = redirect_c ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (IF_imem_rvalid_i) state_d = S_REQ;
        else if (redirect_c)  state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (IF_imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Datapath next values: PC, pending PC, IF/ID register and skid buffer.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    // Redirect wins over the increment.
    if (redirect_c) begin
      pc_d = target_c;
    end else if (accept_c) begin
      pc_d = pc_q + DATA_WIDTH'(4);
    end
    if (accept_c) pend_pc_d = pc_q;

    if (redirect_c) begin
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      out_pc_d     = '0;
      skid_valid_d = 1'b0;
    end else if (!ID_stall_i) begin
      // Skid entry is older than any new delivery (they cannot coincide anyway).
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (deliver_c) begin
        out_valid_d = 1'b1;
        out_instr_d = IF_imem_rdata_i;
        out_pc_d    = pend_pc_q;
      end else begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
        out_pc_d    = '0;
      end
    end else if (deliver_c) begin
      // Stalled: an empty output slot may still be filled, otherwise park in the skid.
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_instr_d = IF_imem_rdata_i;
        out_pc_d    = pend_pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = IF_imem_rdata_i;
        skid_pc_d    = pend_pc_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q   <= 1'b0;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      rst_done_q   <= 1'b1;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign IF_imem_req_o    = req_c;
  assign IF_imem_addr_o   = pc_q;
  assign IF_instruction_o = out_instr_q;
  assign IF_pc_o          = out_pc_q;
  assign IF_valid_o       = out_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle-by-cycle vector table for streaming, stall/skid
// and redirect cases, a second instance for PC wraparound, and hand-written
// sequences for delayed-response redirect and asynchronous reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XMSK = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        req, ready, rvalid;
  logic [31:0] addr, rdata;
  logic        stall, pcsrc;
  logic [31:0] tgt;
  logic [31:0] instr, pc;
  logic        valid;

  logic        req2, rvalid2;
  logic [31:0] addr2, rdata2, instr2, pc2;
  logic        valid2;
  logic        zero1;
  logic [31:0] zero32;

  int checks = 0;
  int errors = 0;
  int unsigned mem_lat;
  logic        busy;
  int unsigned cnt;

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vec [NVEC];

  fetch_stage dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .IF_imem_req_o           (req),
    .IF_imem_addr_o          (addr),
    .IF_imem_ready_i         (ready),
    .IF_imem_rvalid_i        (rvalid),
    .IF_imem_rdata_i         (rdata),
    .ID_stall_i              (stall),
    .ID_PCSrc_i              (pcsrc),
    .ID_branch_target_addr_i (tgt),
    .IF_instruction_o        (instr),
    .IF_pc_o                 (pc),
    .IF_valid_o              (valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .IF_imem_req_o           (req2),
    .IF_imem_addr_o          (addr2),
    .IF_imem_ready_i         (1'b1),
    .IF_imem_rvalid_i        (rvalid2),
    .IF_imem_rdata_i         (rdata2),
    .ID_stall_i              (zero1),
    .ID_PCSrc_i              (zero1),
    .ID_branch_target_addr_i (zero32),
    .IF_instruction_o        (instr2),
    .IF_pc_o                 (pc2),
    .IF_valid_o              (valid2)
  );

  assign zero1  = 1'b0;
  assign zero32 = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: responds mem_lat cycles after acceptance, data = addr ^ A5A5_0000.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
      busy   <= 1'b0;
      cnt    <= 0;
    end else begin
      rvalid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          rvalid <= 1'b1;
          busy   <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (req && ready) begin
        rdata <= addr ^ XMSK;
        if (mem_lat <= 1) rvalid <= 1'b1;
        else begin
          busy <= 1'b1;
          cnt  <= mem_lat - 1;
        end
      end
    end
  end

  // Single-cycle memory for the wraparound instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid2 <= 1'b0;
      rdata2  <= 32'h0;
    end else begin
      rvalid2 <= req2;
      if (req2) rdata2 <= addr2 ^ XMSK;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic s, input logic p, input logic [31:0] t,
                      input logic v, input logic [31:0] epc, input logic [31:0] ei,
                      input logic er, input logic [31:0] ea);
    vec[i].stall   = s;
    vec[i].pcsrc   = p;
    vec[i].tgt     = t;
    vec[i].e_valid = v;
    vec[i].e_pc    = epc;
    vec[i].e_instr = ei;
    vec[i].e_req   = er;
    vec[i].e_addr  = ea;
  endtask

  // Watch for the first request (address check) and the first valid output.
  task automatic wait_result(input string name, input logic [31:0] exp_addr,
                             input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    bit seen = 0;
    bit done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (req && !seen) begin
        chk({name, "_req_addr"}, addr, exp_addr);
        seen = 1;
      end
      if (valid) begin
        chk({name, "_req_before_valid"}, 32'(seen), 32'd1);
        chk({name, "_pc"}, pc, exp_pc);
        chk({name, "_instr"}, instr, exp_instr);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_valid expected=valid_within_30_cycles", name);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ready   = 1'b1;
    stall   = 1'b0;
    pcsrc   = 1'b0;
    tgt     = 32'h0;
    mem_lat = 1;

    //      i  stall pcsrc tgt         valid pc          instr              req  addr
    setv( 0, 0, 0, 32'h0,     0, 32'h0,   NOP,               1, 32'h0);
    setv( 1, 0, 0, 32'h0,     0, 32'h0,   NOP,               0, 32'h4);
    setv( 2, 0, 0, 32'h0,     1, 32'h0,   32'hA5A5_0000,     1, 32'h4);
    setv( 3, 0, 0, 32'h0,     0, 32'h0,   NOP,               0, 32'h8);
    setv( 4, 1, 0, 32'h0,     1, 32'h4,   32'hA5A5_0004,     1, 32'h8);
    setv( 5, 1, 0, 32'h0,     1, 32'h4,   32'hA5A5_0004,     0, 32'hC);
    setv( 6, 1, 0, 32'h0,     1, 32'h4,   32'hA5A5_0004,     0, 32'hC);
    setv( 7, 1, 0, 32'h0,     1, 32'h4,   32'hA5A5_0004,     0, 32'hC);
    setv( 8, 1, 0, 32'h0,     1, 32'h4,   32'hA5A5_0004,     0, 32'hC);
    setv( 9, 0, 0, 32'h0,     1, 32'h4,   32'hA5A5_0004,     0, 32'hC);
    setv(10, 0, 0, 32'h0,     1, 32'h8,   32'hA5A5_0008,     1, 32'hC);
    setv(11, 0, 0, 32'h0,     0, 32'h0,   NOP,               0, 32'h10);
    setv(12, 0, 0, 32'h0,     1, 32'hC,   32'hA5A5_000C,     1, 32'h10);
    setv(13, 0, 1, 32'h200,   0, 32'h0,   NOP,               0, 32'h14);
    setv(14, 0, 0, 32'h0,     0, 32'h0,   NOP,               1, 32'h200);
    setv(15, 0, 0, 32'h0,     0, 32'h0,   NOP,               0, 32'h204);
    setv(16, 0, 1, 32'h7E,    1, 32'h200, 32'hA5A5_0200,     1, 32'h204);
    setv(17, 0, 0, 32'h0,     0, 32'h0,   NOP,               0, 32'h7C);
    setv(18, 0, 0, 32'h0,     0, 32'h0,   NOP,               1, 32'h7C);
    setv(19, 0, 0, 32'h0,     0, 32'h0,   NOP,               0, 32'h80);
    setv(20, 1, 1, 32'h300,   1, 32'h7C,  32'hA5A5_007C,     1, 32'h80);
    setv(21, 0, 0, 32'h0,     1, 32'h7C,  32'hA5A5_007C,     0, 32'h84);
    setv(22, 0, 0, 32'h0,     1, 32'h80,  32'hA5A5_0080,     1, 32'h84);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wrap_addr", addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Cycle-by-cycle table
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      stall = vec[i].stall;
      pcsrc = vec[i].pcsrc;
      tgt   = vec[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vec[i].e_valid));
      chk($sformatf("v%0d_pc", i), pc, vec[i].e_pc);
      chk($sformatf("v%0d_instr", i), instr, vec[i].e_instr);
      chk($sformatf("v%0d_req", i), 32'(req), 32'(vec[i].e_req));
      chk($sformatf("v%0d_addr", i), addr, vec[i].e_addr);
      if (i == 2) begin
        chk("wrap_req", 32'(req2), 32'd1);
        chk("wrap_addr", addr2, 32'h0);
        chk("wrap_valid", 32'(valid2), 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_instr", instr2, 32'h5A5A_FFFC);
      end
    end
    stall = 1'b0;
    pcsrc = 1'b0;
    tgt   = 32'h0;

    // Redirect while waiting on a slow response: stale data must be dropped.
    mem_lat = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_wait_req", 32'(req), 32'd0);
    chk("t3_wait_rvalid", 32'(rvalid), 32'd0);
    pcsrc = 1'b1;
    tgt   = 32'h7C;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    tgt   = 32'h0;
    chk("t3_bubble_valid", 32'(valid), 32'd0);
    chk("t3_bubble_instr", instr, NOP);
    wait_result("t3", 32'h7C, 32'h7C, 32'hA5A5_007C);

    // Asynchronous reset in S_WAIT with the output valid.
    stall = 1'b1;
    @(posedge clk); #1;
    chk("t6_pre_valid", 32'(valid), 32'd1);
    chk("t6_pre_req", 32'(req), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_instr", instr, NOP);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_req", 32'(req), 32'd0);
    chk("t6_rst_addr", addr, 32'h0);
    chk("t6_rst_wrap_addr", addr2, 32'hFFFF_FFFC);
    stall   = 1'b0;
    mem_lat = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_result("t6", 32'h0, 32'h0, 32'hA5A5_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
